// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared state encoding and constants for the CPU pipeline control blocks.
package cpu_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    ERR      = 2'd3
  } state_e;
  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [4:0] REG_ZERO  = 5'd0;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a load in EX whose destination is read by the instruction in ID.
module load_use_detect
  import cpu_ctrl_pkg::*;
(
  input  logic       mem_read_i,
  input  logic [4:0] ex_rt_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  output logic       hazard_o
);
  // $zero never carries a real dependency
  assign hazard_o = mem_read_i && (ex_rt_i != REG_ZERO) && (ex_rt_i == id_rs_i || ex_rt_i == id_rt_i);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall, branch flush and memory-wait freeze sequencing
// for the 5-stage pipeline, with a saturating stall counter and sticky memory timeout.
module pipeline_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             ID_EX_MemRead_i,
  input  logic [4:0]       ID_EX_RTaddr_i,
  input  logic [4:0]       IF_ID_RSaddr_i,
  input  logic [4:0]       IF_ID_RTaddr_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             hold_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o
);
  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);
  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             timeout_q, timeout_d;
  logic             lu, active, mem_stall, run_rules;
  load_use_detect u_lud (
    .mem_read_i (ID_EX_MemRead_i),
    .ex_rt_i    (ID_EX_RTaddr_i),
    .id_rs_i    (IF_ID_RSaddr_i),
    .id_rt_i    (IF_ID_RTaddr_i),
    .hazard_o   (lu)
  );
  // An ack in MEM_WAIT releases the freeze that same cycle, so the normal RUN rules take over
  always_comb begin
    active         = (state_q == RUN) || (state_q == MEM_WAIT);
    mem_stall      = (state_q == RUN) ? (dmem_req_i && !dmem_ack_i) :
                     (state_q == MEM_WAIT) ? !dmem_ack_i : 1'b0;
    run_rules      = active && !mem_stall;
    pc_write_o     = run_rules && !lu;
    if_id_write_o  = run_rules && !lu;
    id_ex_bubble_o = run_rules && lu;
    if_id_flush_o  = run_rules && !lu && branch_taken_i;
    hold_o         = !run_rules;
    timeout_o      = timeout_q;
    stall_cnt_o    = stall_q;
  end
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    stall_d   = (active && !pc_write_o && stall_q != '1) ? stall_q + 1'b1 : stall_q;
    case (state_q)
      IDLE: state_d = start_i ? RUN : IDLE;
      RUN: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
          wait_d  = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ack_i) begin
          state_d = RUN;
          wait_d  = 8'd0;
        end else if (wait_q == WAIT_LIM) begin
          state_d   = ERR;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ERR: state_d = ERR;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      wait_q    <= 8'd0;
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end
endmodule
